// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
package ysyx_23060332_ifu_pkg;

  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] inst_addr_bus_t;

  localparam inst_addr_bus_t RESET_PC = 32'h8000_0000;
  localparam inst_bus_t      INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  // Redirect targets are word addresses; the two low bits are forced to zero.
  function automatic inst_addr_bus_t word_target(input logic [29:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding imem read, instruction held for the IDU
// until consumed, EXU redirects squash whatever is in flight or held.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | imem_req_valid asserted with pc, waiting for accept
// WAIT  | request accepted, waiting for response (dropped if discard set)
// HOLD  | instruction presented to IDU until fire or redirect
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        inst_valid,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr,
  input  logic        inst_ready
);

  ifu_state_e     state_q, state_d;
  inst_addr_bus_t pc_q, pc_d;
  inst_bus_t      inst_q;
  inst_addr_bus_t addr_q;
  logic           discard_q, discard_d;
  logic           capture;
  logic           unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    capture   = 1'b0;
    case (state_q)
      IFU_IDLE: state_d = IFU_REQ;
      IFU_REQ: begin
        if (imem_req_ready) begin
          state_d   = IFU_WAIT;
          discard_d = jump_en;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (discard_q || jump_en) begin
            state_d   = IFU_REQ;
            discard_d = 1'b0;
          end else begin
            state_d = IFU_HOLD;
            capture = 1'b1;
          end
        end else if (jump_en) begin
          discard_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (jump_en) begin
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          state_d = IFU_REQ;
          pc_d    = pc_q + 32'd4;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
    // Redirect wins over sequential advance everywhere except the reset cycle.
    if (jump_en && (state_q != IFU_IDLE)) begin
      pc_d = word_target(jump_addr[31:2]);
    end
  end

  always_comb begin
    imem_req_valid = (state_q == IFU_REQ);
    imem_req_addr  = pc_q;
    inst_valid     = (state_q == IFU_HOLD) && !jump_en;
    inst_o         = inst_q;
    inst_addr      = addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      inst_q    <= INST_NOP;
      addr_q    <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if (capture) begin
        inst_q <= imem_rsp_data;
        addr_q <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Bench for the fetch unit: directed scenarios plus random memory/IDU/redirect traffic
// checked against a program-counter reference model.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        inst_ready;

  ysyx_23060332_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .jump_en(jump_en), .jump_addr(jump_addr),
    .inst_valid(inst_valid), .inst_o(inst_o), .inst_addr(inst_addr),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: address of the next instruction in program order
  logic [31:0] exp_pc;
  int          fires;
  bit          last_fire;

  // memory responder
  bit          pending;
  int          rsp_cnt;
  logic [31:0] pend_addr;
  int          dly_min, dly_max;
  bit          rsp_bad;

  logic        d_ready, d_iready, d_jump;
  logic [31:0] d_jaddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst_o"}, inst_o, NOP);
    chk({tag, "_inst_addr"}, inst_addr, RST_PC);
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update the model.
  task automatic step();
    @(negedge clk);
    imem_req_ready = d_ready;
    inst_ready     = d_iready;
    jump_en        = d_jump;
    jump_addr      = d_jaddr;
    if (pending && rsp_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = rsp_bad ? 32'hDEAD_BEEF : mem_word(pend_addr);
      pending        = 1'b0;
      rsp_bad        = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pending) rsp_cnt--;
    end
    #1;
    if (jump_en) chk("squash_gate", {31'd0, inst_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      pending   = 1'b1;
      pend_addr = imem_req_addr;
      rsp_cnt   = $urandom_range(dly_max, dly_min);
    end
    last_fire = inst_valid && inst_ready;
    if (last_fire) begin
      chk("inst_addr", inst_addr, exp_pc);
      chk("inst_o", inst_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      fires++;
    end
    if (jump_en) exp_pc = {jump_addr[31:2], 2'b00};
  endtask

  task automatic run_until_fire(input string tag);
    int n = 0;
    last_fire = 1'b0;
    while (!last_fire && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, last_fire}, 32'd1);
  endtask

  task automatic reach_hold(input string tag);
    int n = 0;
    d_iready = 1'b0;
    step();
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'd0, inst_valid}, 32'd1);
  endtask

  logic [8:0]  pat_r, pat_i;
  logic [31:0] held_o, held_a;
  int          f0;

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    jump_en = 1'b0; jump_addr = '0; inst_ready = 1'b0;
    d_ready = 1'b0; d_iready = 1'b1; d_jump = 1'b0; d_jaddr = '0;
    exp_pc = RST_PC; fires = 0; last_fire = 1'b0;
    pending = 1'b0; rsp_cnt = 0; pend_addr = '0; dly_min = 0; dly_max = 0; rsp_bad = 1'b0;

    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_cycle", {31'd0, imem_req_valid}, 32'd0);

    // request held while memory is not ready
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_req_addr, RST_PC);
    end

    // zero-wait memory, IDU always ready: 3 cycles per instruction
    d_ready = 1'b1;
    f0 = fires;
    for (int i = 0; i < 9; i++) begin
      step();
      pat_r[i] = imem_req_valid;
      pat_i[i] = inst_valid;
    end
    chk("zw_req_pattern", {23'd0, pat_r}, 32'h049);
    chk("zw_valid_pattern", {23'd0, pat_i}, 32'h124);
    chk("zw_fires", fires - f0, 3);

    // IDU stalls in HOLD
    d_iready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin held_o = inst_o; held_a = inst_addr; end
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("hold_inst_o", inst_o, held_o);
      chk("hold_inst_addr", inst_addr, held_a);
    end
    chk("hold_addr_value", held_a, 32'h8000_000C);
    chk("hold_pc_frozen", exp_pc, 32'h8000_000C);
    d_iready = 1'b1;
    step();

    // redirect while waiting: late response must be dropped
    dly_min = 2; dly_max = 2; rsp_bad = 1'b1;
    step();
    d_jump = 1'b1; d_jaddr = 32'h8000_0100;
    step();
    d_jump = 1'b0;
    dly_min = 0; dly_max = 0;
    run_until_fire("jw_fire");
    chk("jw_inst_addr", inst_addr, 32'h8000_0100);

    // redirect in HOLD with IDU ready the same cycle
    reach_hold("jh_reach_hold");
    d_jump = 1'b1; d_jaddr = 32'h8000_0203; d_iready = 1'b1;
    step();
    chk("jh_valid_low", {31'd0, inst_valid}, 32'd0);
    d_jump = 1'b0;
    run_until_fire("jh_fire");
    chk("jh_inst_addr", inst_addr, 32'h8000_0200);

    // PC wraps past the top of the address space
    reach_hold("wrap_reach_hold");
    d_jump = 1'b1; d_jaddr = 32'hFFFF_FFFF; d_iready = 1'b1;
    step();
    d_jump = 1'b0;
    run_until_fire("wrap_fire0");
    chk("wrap_addr0", inst_addr, 32'hFFFF_FFFC);
    run_until_fire("wrap_fire1");
    chk("wrap_addr1", inst_addr, 32'h0000_0000);

    // reset asserted while waiting for a response
    dly_min = 3; dly_max = 3;
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    pending = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RST_PC;
    #1 chk("midrst_idle", {31'd0, imem_req_valid}, 32'd0);
    dly_min = 0; dly_max = 0;
    run_until_fire("midrst_fire");
    chk("midrst_inst_addr", inst_addr, RST_PC);

    // random traffic
    dly_min = 0; dly_max = 3;
    f0 = fires;
    for (int i = 0; i < 800; i++) begin
      d_ready  = ($urandom % 4) != 0;
      d_iready = ($urandom % 10) < 7;
      d_jump   = ($urandom % 20) == 0;
      d_jaddr  = ($urandom % 3 != 0) ? (RST_PC + $urandom_range(0, 1023)) : $urandom;
      step();
    end
    chk("rand_progress", {31'd0, (fires - f0) >= 20}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060332_ifu.md
# ysyx_23060332_ifu

Instruction fetch unit for the NPC core: holds the PC, issues one instruction-memory read per instruction over a valid/ready request channel, and presents the fetched word plus its address to the IDU through a valid/ready handshake. Control-flow redirects from the EXU (JAL/JALR targets) overwrite the PC and squash any in-flight or held fetch. Single outstanding request; multicycle, non-pipelined.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address (current PC).
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  read data valid; arrives no earlier than the cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `jump_en`  in  1  single-cycle redirect strobe from EXU.
- `jump_addr`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `inst_valid`  out  1  instruction available to IDU.
- `inst_o`  out  32  instruction word.
- `inst_addr`  out  32  address of `inst_o`.
- `inst_ready`  in  1  IDU consumes instruction this cycle.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: `pc`, `inst_q`, `addr_q`, `discard`.
- IDLE: entered only from reset; unconditionally → REQ next edge.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready` → WAIT. Address may change before acceptance (responder samples only on accept).
- WAIT: on `imem_rsp_valid`: if `discard`=0 capture `inst_q`←data, `addr_q`←`pc`, → HOLD; if `discard`=1 drop data, clear `discard`, → REQ.
- HOLD: `inst_valid`=1. Fire (`inst_valid`&`inst_ready`): `pc`←`pc`+4 (mod 2^32 wrap), → REQ.
- Redirect (`jump_en`=1), highest priority in every state except IDLE: `pc`←{jump_addr[31:2],2'b00}, and
  - REQ without accept: stay REQ, new address next cycle.
  - REQ with accept same cycle: old request is in flight → WAIT with `discard`=1.
  - WAIT, no response: `discard`←1, stay WAIT.
  - WAIT with response same cycle: drop data, → REQ.
  - HOLD: held instruction flushed, no PC+4, → REQ.
- `inst_valid` = (state==HOLD) & !`jump_en` (combinational gating so a squashed instruction is never handed over).
- Response in REQ/HOLD/IDLE is a protocol violation; ignored.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `inst_valid`=0, `inst_o`=`INST_NOP` (32'h0000_0013), `inst_addr`=`RESET_PC`, `pc`=`RESET_PC`, `discard`=0, state IDLE.
- Reset asserted mid-operation: all above values immediately; outstanding response after release is not expected (memory reset with core).
- Zero-wait memory (ready=1, rsp next cycle), IDU always ready: REQ t, WAIT t+1, HOLD t+2, REQ t+3 → 3 cycles/instruction.
- First request: second cycle after reset release.
- `inst_o`/`inst_addr` stable throughout HOLD until fire or redirect.

## Structure
- Add to `ysyx_23060332_define.v`: `RESET_PC` value, IFU state encodings (2-bit), reuse `InstBus`, `InstAddrBus`, `INST_NOP`.
- Single module; no sub-module warranted. PC adder inline.

## Test plan
- Reset release, ready=1, rsp 1-cycle, IDU ready: req addrs 0x80000000, 0x80000004, 0x80000008; `inst_valid` every 3rd cycle with matching `inst_addr`.
- `imem_req_ready` low 4 cycles: `imem_req_valid` held, addr 0x80000000 stable, no state advance.
- IDU `inst_ready` low 5 cycles in HOLD: `inst_o`/`inst_addr` unchanged, no new request, PC not incremented.
- `jump_en` to 0x80000100 while WAIT: late response (data 0xDEADBEEF) dropped, next request 0x80000100, delivered instruction from 0x80000100.
- `jump_en` to 0x80000203 in HOLD with `inst_ready`=1 same cycle: `inst_valid` low that cycle, next request 0x80000200, no PC+4.
- `rst` asserted in WAIT: outputs return to reset values same cycle; after release first request 0x80000000.
